// File: rtl/learn_pkg.sv
// Shared types and helpers for the note-by-note practice controller.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package learn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROMPT,
        ST_WAIT,
        ST_ADVANCE,
        ST_DONE
    } state_t;

    localparam int unsigned REST_NOTE = 0;

    // Time band gives the base grade; every `pen` mistakes knocks one level off, floored at 0.
    function automatic logic [1:0] grade(
        input int unsigned sec,
        input int unsigned miss,
        input int unsigned t_a,
        input int unsigned t_b,
        input int unsigned t_c,
        input int unsigned pen
    );
        int unsigned base;
        int unsigned cut;
        if (sec < t_a)      base = 3;
        else if (sec < t_b) base = 2;
        else if (sec < t_c) base = 1;
        else                base = 0;
        cut = miss / pen;
        return (base > cut) ? 2'(base - cut) : 2'd0;
    endfunction

endpackage

// File: rtl/sec_timer.sv
// Elapsed-seconds timer: prescaler of TICK_DIV cycles feeding a saturating seconds counter.
// Latency: sec updates the cycle after the prescaler wraps; clr takes effect next cycle.
// Backpressure: none; en gates counting, clr has priority over en.
module sec_timer #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned TIME_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [TIME_W-1:0] sec
);

    localparam int unsigned     PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [TIME_W-1:0] sec_q, sec_d;

    always_comb begin
        pre_d = pre_q;
        sec_d = sec_q;
        if (clr) begin
            pre_d = '0;
            sec_d = '0;
        end else if (en) begin
            if (pre_q == PRE_MAX) begin
                pre_d = '0;
                if (sec_q != '1) sec_d = sec_q + 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
            sec_q <= '0;
        end else begin
            pre_q <= pre_d;
            sec_q <= sec_d;
        end
    end

    assign sec = sec_q;

endmodule

// File: rtl/learn_mode_ctrl.sv
// Practice controller: prompts each song note on the buzzer, waits for the matching key, grades the run.
// Latency: one cycle per state step; prompt lasts lib_duration cycles (0 treated as 1); ADVANCE is one cycle.
// Backpressure: none; start restarts from any state and wins over a simultaneous press or expiry.
module learn_mode_ctrl
    import learn_pkg::*;
#(
    parameter int unsigned NOTE_W   = 4,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned SONG_LEN = 25,
    parameter int unsigned DUR_W    = 26,
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned TIME_W   = 16,
    parameter int unsigned MISS_W   = 8,
    parameter int unsigned T_A      = 30,
    parameter int unsigned T_B      = 60,
    parameter int unsigned T_C      = 80,
    parameter int unsigned MISS_PEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NOTE_W-1:0] key_code,
    input  logic              key_valid,
    output logic [IDX_W-1:0]  lib_index,
    input  logic [NOTE_W-1:0] lib_note,
    input  logic [DUR_W-1:0]  lib_duration,
    output logic [NOTE_W-1:0] note_to_play,
    output logic              play_note,
    output logic              note_buzzed,
    output logic              busy,
    output logic              done,
    output logic [TIME_W-1:0] elapsed_sec,
    output logic [MISS_W-1:0] mistakes,
    output logic [1:0]        level
);

    if (SONG_LEN < 1 || SONG_LEN > (2**IDX_W) - 1) begin : g_bad_song_len
        $error("learn_mode_ctrl: SONG_LEN out of range for IDX_W");
    end
    if (MISS_PEN < 1) begin : g_bad_miss_pen
        $error("learn_mode_ctrl: MISS_PEN must be at least 1");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DUR_W-1:0]  cnt_q, cnt_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [1:0]        lvl_q, lvl_d;
    logic              key_prev_q, key_prev_d;
    logic              entry_q, entry_d;
    logic              adv_seen_q, adv_seen_d;

    logic [DUR_W-1:0]  dur_eff;
    logic              expire;
    logic              press;
    logic              key_hit;
    logic              is_rest;
    logic              in_prompt;
    logic              timer_en;

    assign dur_eff   = (lib_duration == '0) ? DUR_W'(1) : lib_duration;
    assign expire    = (cnt_q == dur_eff - 1'b1);
    assign press     = key_valid & ~key_prev_q;
    assign key_hit   = (key_code == lib_note);
    assign is_rest   = (lib_note == NOTE_W'(REST_NOTE));
    assign in_prompt = (state_q == ST_PROMPT);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        miss_d     = miss_q;
        lvl_d      = lvl_q;
        entry_d    = 1'b0;
        adv_seen_d = adv_seen_q;
        key_prev_d = key_valid;

        if (start) begin
            state_d    = ST_PROMPT;
            idx_d      = '0;
            cnt_d      = '0;
            miss_d     = '0;
            lvl_d      = 2'd0;
            entry_d    = 1'b1;
            adv_seen_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_PROMPT: begin
                    if (expire) begin
                        cnt_d   = '0;
                        state_d = is_rest ? ST_ADVANCE : ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (press) begin
                        if (key_hit)            state_d = ST_ADVANCE;
                        else if (miss_q != '1)  miss_d  = miss_q + 1'b1;
                    end
                end
                ST_ADVANCE: begin
                    adv_seen_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        lvl_d   = grade(32'(elapsed_sec), 32'(miss_q), T_A, T_B, T_C, MISS_PEN);
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = '0;
                        entry_d = 1'b1;
                        state_d = ST_PROMPT;
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            miss_q     <= '0;
            lvl_q      <= 2'd0;
            key_prev_q <= 1'b0;
            entry_q    <= 1'b0;
            adv_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            miss_q     <= miss_d;
            lvl_q      <= lvl_d;
            key_prev_q <= key_prev_d;
            entry_q    <= entry_d;
            adv_seen_q <= adv_seen_d;
        end
    end

    // The clock only starts once the first note is cleared, and stops as the run leaves busy.
    assign timer_en = busy & (adv_seen_q | (state_q == ST_ADVANCE));

    sec_timer #(
        .TICK_DIV (TICK_DIV),
        .TIME_W   (TIME_W)
    ) u_sec_timer (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (timer_en),
        .sec (elapsed_sec)
    );

    assign lib_index    = idx_q;
    assign busy         = (state_q == ST_PROMPT) | (state_q == ST_WAIT) | (state_q == ST_ADVANCE);
    assign done         = (state_q == ST_DONE);
    assign note_buzzed  = in_prompt & entry_q;
    assign play_note    = in_prompt & ~is_rest;
    assign note_to_play = in_prompt ? lib_note : '0;
    assign mistakes     = miss_q;
    assign level        = done ? lvl_q : 2'd0;

endmodule

// File: tb/tb_learn_mode_ctrl.sv
// Bench for learn_mode_ctrl: directed scenarios plus random runs, every cycle compared with a reference model.
module tb_learn_mode_ctrl;

    localparam int NOTE_W = 4, IDX_W = 5, SONG_LEN = 3, DUR_W = 8;
    localparam int TICK = 100, TIME_W = 7, MISS_W = 3;
    localparam int T_A = 30, T_B = 60, T_C = 80, PEN = 4;
    localparam int TMAX = (1 << TIME_W) - 1;
    localparam int MMAX = (1 << MISS_W) - 1;
    localparam int PH_IDLE = 0, PH_PROMPT = 1, PH_WAIT = 2, PH_ADV = 3, PH_DONE = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [NOTE_W-1:0] key_code = '0;
    logic              key_valid = 1'b0;
    logic [IDX_W-1:0]  lib_index;
    logic [NOTE_W-1:0] lib_note;
    logic [DUR_W-1:0]  lib_duration;
    logic [NOTE_W-1:0] note_to_play;
    logic              play_note, note_buzzed, busy, done;
    logic [TIME_W-1:0] elapsed_sec;
    logic [MISS_W-1:0] mistakes;
    logic [1:0]        level;

    logic [NOTE_W-1:0] song_note [32];
    logic [DUR_W-1:0]  song_dur  [32];

    assign lib_note     = song_note[lib_index];
    assign lib_duration = song_dur[lib_index];

    always #5 clk = ~clk;

    learn_mode_ctrl #(
        .NOTE_W(NOTE_W), .IDX_W(IDX_W), .SONG_LEN(SONG_LEN), .DUR_W(DUR_W),
        .TICK_DIV(TICK), .TIME_W(TIME_W), .MISS_W(MISS_W),
        .T_A(T_A), .T_B(T_B), .T_C(T_C), .MISS_PEN(PEN)
    ) dut (
        .clk(clk), .rst(rst_n), .start(start), .key_code(key_code), .key_valid(key_valid),
        .lib_index(lib_index), .lib_note(lib_note), .lib_duration(lib_duration),
        .note_to_play(note_to_play), .play_note(play_note), .note_buzzed(note_buzzed),
        .busy(busy), .done(done), .elapsed_sec(elapsed_sec), .mistakes(mistakes), .level(level)
    );

    int n_checks = 0;
    int n_errors = 0;
    int buzz_cnt = 0;

    // Reference model: phase, current note, prompt cycles left, total timed cycles.
    int m_ph, m_idx, m_rem, m_miss, m_tcyc, m_lvl;
    bit m_first, m_adv, m_kprev;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_sec();
        return (m_tcyc / TICK > TMAX) ? TMAX : m_tcyc / TICK;
    endfunction

    function automatic int grade_ref(input int sec, input int miss);
        int base;
        base = (sec < T_A) ? 3 : (sec < T_B) ? 2 : (sec < T_C) ? 1 : 0;
        return (base - miss / PEN < 0) ? 0 : base - miss / PEN;
    endfunction

    task automatic model_reset();
        m_ph = PH_IDLE; m_idx = 0; m_rem = 0; m_miss = 0; m_tcyc = 0; m_lvl = 0;
        m_first = 0; m_adv = 0; m_kprev = 0;
    endtask

    task automatic enter_prompt();
        m_ph    = PH_PROMPT;
        m_first = 1;
        m_rem   = (song_dur[m_idx] == 0) ? 1 : int'(song_dur[m_idx]);
    endtask

    task automatic compare_all();
        int  note;
        bit  prm;
        note = int'(song_note[m_idx]);
        prm  = (m_ph == PH_PROMPT);
        check_eq("busy",        32'(busy),         32'(m_ph == PH_PROMPT || m_ph == PH_WAIT || m_ph == PH_ADV));
        check_eq("done",        32'(done),         32'(m_ph == PH_DONE));
        check_eq("lib_index",   32'(lib_index),    32'(m_idx));
        check_eq("note_buzzed", 32'(note_buzzed),  32'(prm && m_first));
        check_eq("play_note",   32'(play_note),    32'(prm && note != 0));
        check_eq("note_to_play",32'(note_to_play), prm ? 32'(note) : 32'd0);
        check_eq("mistakes",    32'(mistakes),     32'(m_miss));
        check_eq("elapsed_sec", 32'(elapsed_sec),  32'(exp_sec()));
        check_eq("level",       32'(level),        (m_ph == PH_DONE) ? 32'(m_lvl) : 32'd0);
    endtask

    task automatic model_step(input bit st, input bit kv, input int kc);
        int note, sec;
        bit press, bsy;
        note  = int'(song_note[m_idx]);
        sec   = exp_sec();
        press = kv && !m_kprev;
        bsy   = (m_ph == PH_PROMPT || m_ph == PH_WAIT || m_ph == PH_ADV);
        m_kprev = kv;
        if (st) begin
            m_idx = 0; m_miss = 0; m_tcyc = 0; m_adv = 0; m_lvl = 0;
            enter_prompt();
        end else begin
            if (bsy && (m_adv || m_ph == PH_ADV)) m_tcyc++;
            case (m_ph)
                PH_PROMPT: begin
                    m_first = 0;
                    if (m_rem == 1) m_ph = (note == 0) ? PH_ADV : PH_WAIT;
                    else            m_rem--;
                end
                PH_WAIT: if (press) begin
                    if (kc == note)       m_ph = PH_ADV;
                    else if (m_miss < MMAX) m_miss++;
                end
                PH_ADV: begin
                    m_adv = 1;
                    if (m_idx == SONG_LEN - 1) begin
                        m_lvl = grade_ref(sec, m_miss);
                        m_ph  = PH_DONE;
                    end else begin
                        m_idx++;
                        enter_prompt();
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit st, input bit kv, input int kc);
        @(negedge clk);
        rst_n = 1'b1; start = st; key_valid = kv; key_code = NOTE_W'(kc);
        #1;
        compare_all();
        if (note_buzzed) buzz_cnt++;
        model_step(st, kv, kc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; key_valid = 1'b0;
        #1;
        model_reset();
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0);
    endtask

    task automatic press(input int kc, input int hold);
        repeat (hold) cyc(0, 1, kc);
        cyc(0, 0, kc);
    endtask

    task automatic run_until(input int ph, input int budget, input string tag);
        int n = 0;
        while (m_ph != ph && n < budget) begin
            cyc(0, 0, 0);
            n++;
        end
        if (m_ph != ph) check_eq(tag, 32'(m_ph), 32'(ph));
    endtask

    task automatic load3(input int n0, d0, n1, d1, n2, d2);
        for (int i = 0; i < 32; i++) begin song_note[i] = '0; song_dur[i] = '0; end
        song_note[0] = NOTE_W'(n0); song_dur[0] = DUR_W'(d0);
        song_note[1] = NOTE_W'(n1); song_dur[1] = DUR_W'(d1);
        song_note[2] = NOTE_W'(n2); song_dur[2] = DUR_W'(d2);
    endtask

    initial begin
        bit kv;
        int kc;
        load3(5, 10, 3, 10, 7, 10);
        model_reset();
        do_reset();
        idle(3);

        // Clean run: three prompts of 10, correct key 5 cycles after each prompt ends.
        buzz_cnt = 0;
        cyc(1, 0, 0);
        for (int n = 0; n < 3; n++) begin
            run_until(PH_WAIT, 50, "tmo_clean_wait");
            idle(4);
            press(int'(song_note[n]), 2);
        end
        run_until(PH_DONE, 50, "tmo_clean_done");
        idle(1);
        check_eq("clean_buzz_cnt", 32'(buzz_cnt), 32'd3);
        check_eq("clean_done", 32'(done), 32'd1);
        check_eq("clean_miss", 32'(mistakes), 32'd0);
        check_eq("clean_level", 32'(level), 32'd3);

        // Press in prompt ignored, two held wrong keys, held correct key, then a rest note.
        load3(9, 10, 0, 8, 4, 6);
        cyc(1, 0, 0);
        idle(2);
        press(3, 3);
        run_until(PH_WAIT, 50, "tmo_hold_wait");
        check_eq("prompt_press_miss", 32'(mistakes), 32'd0);
        check_eq("prompt_press_busy", 32'(busy), 32'd1);
        press(1, 50);
        press(2, 50);
        check_eq("held_wrong_miss", 32'(mistakes), 32'd2);
        check_eq("held_wrong_idx", 32'(lib_index), 32'd0);
        press(9, 50);
        check_eq("held_right_idx", 32'(lib_index), 32'd2);
        check_eq("held_right_miss", 32'(mistakes), 32'd2);
        press(4, 2);
        run_until(PH_DONE, 50, "tmo_hold_done");
        idle(1);
        check_eq("hold_level", 32'(level), 32'd3);

        // Reset while waiting for a key, then restart.
        load3(5, 10, 3, 10, 7, 10);
        cyc(1, 0, 0);
        run_until(PH_WAIT, 50, "tmo_rst_wait");
        do_reset();
        check_eq("rst_busy", 32'(busy), 32'd0);
        idle(2);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check_eq("rst_restart_idx", 32'(lib_index), 32'd0);
        idle(1);

        // Slow run: about 65 s with 5 mistakes, then start while done.
        load3(2, 10, 4, 10, 6, 10);
        cyc(1, 0, 0);
        run_until(PH_WAIT, 50, "tmo_slow_w0");
        press(2, 2);
        run_until(PH_WAIT, 50, "tmo_slow_w1");
        repeat (5) begin press(7, 3); idle(5); end
        for (int n = 0; n < 8000 && m_tcyc < 6500; n++) cyc(0, 0, 0);
        press(4, 2);
        run_until(PH_WAIT, 50, "tmo_slow_w2");
        press(6, 2);
        run_until(PH_DONE, 50, "tmo_slow_done");
        idle(1);
        check_eq("slow_miss", 32'(mistakes), 32'd5);
        check_eq("slow_sec_band", 32'(elapsed_sec >= 60 && elapsed_sec < 80), 32'd1);
        check_eq("slow_level", 32'(level), 32'd0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check_eq("restart_done", 32'(done), 32'd0);
        check_eq("restart_idx", 32'(lib_index), 32'd0);

        // Saturation of both counters.
        run_until(PH_WAIT, 50, "tmo_sat_w0");
        press(2, 2);
        run_until(PH_WAIT, 50, "tmo_sat_w1");
        repeat (9) press(8, 2);
        idle(13000);
        check_eq("sat_miss", 32'(mistakes), 32'(MMAX));
        check_eq("sat_sec", 32'(elapsed_sec), 32'(TMAX));

        // Random songs and key activity, including restarts mid-run.
        for (int r = 0; r < 20; r++) begin
            do_reset();
            for (int i = 0; i < SONG_LEN; i++) begin
                song_note[i] = ($urandom_range(0, 4) == 0) ? '0 : NOTE_W'($urandom_range(1, 15));
                song_dur[i]  = DUR_W'($urandom_range(0, 12));
            end
            kv = 0;
            kc = 0;
            cyc(1, 0, 0);
            for (int c = 0; c < 400; c++) begin
                if (kv) begin
                    if ($urandom_range(0, 2) == 0) kv = 0;
                end else if ($urandom_range(0, 3) == 0) begin
                    kv = 1;
                    kc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : int'(song_note[m_idx]);
                end
                cyc($urandom_range(0, 299) == 0, kv, kc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/learn_mode_ctrl.md
Name: learn_mode_ctrl

Overview:
Parametrised successor to the single-song practice controller: it steps a player through a song, note by note. For each note it prompts by sounding the note for its duration, then waits for the matching key. It counts wrong keys, times the run in seconds and grades the result into a 2-bit level. It sits between the key scanner and the song library (addressed via lib_index), and feeds the buzzer and display blocks.

Parameters:
NOTE_W, 4, width of note code; code 0 = rest
IDX_W, 5, width of note index
SONG_LEN, 25, notes per song (1..2^IDX_W-1)
DUR_W, 26, width of duration in clk cycles
TICK_DIV, 100000000, clk cycles per elapsed-time second
TIME_W, 16, elapsed-seconds width
MISS_W, 8, mistake counter width
T_A, 30, seconds bound for level 3
T_B, 60, seconds bound for level 2
T_C, 80, seconds bound for level 1
MISS_PEN, 4, mistakes costing one level

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse; begins or restarts a run
key_code  in  NOTE_W  current key from scanner
key_valid  in  1  level, high while a key is held
lib_index  out  IDX_W  note index presented to the song library
lib_note  in  NOTE_W  note at lib_index (combinational lib)
lib_duration  in  DUR_W  prompt length in cycles at lib_index
note_to_play  out  NOTE_W  note for the buzzer
play_note  out  1  buzzer enable
note_buzzed  out  1  one-cycle pulse at start of each prompt
busy  out  1  run in progress
done  out  1  held high from run completion until next start
elapsed_sec  out  TIME_W  seconds since first note accepted, saturating
mistakes  out  MISS_W  wrong-key presses, saturating
level  out  2  grade; valid while done=1, else 0

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, including lib_index, counters and the key-edge register.
- Key events: press = key_valid rising edge (registered previous value). Holding a key produces exactly one event.
- States and transitions:
  - IDLE: waits for start. On start: lib_index=0, clear elapsed/mistakes/done, go to PROMPT.
  - PROMPT:
    - Entry cycle: note_buzzed=1 for one cycle; note_to_play=lib_note; play_note=1 (0 if lib_note==0).
    - A duration counter runs lib_duration cycles. lib_duration==0 is treated as 1.
    - When it expires: play_note=0. A rest goes to ADVANCE; any other note goes to WAIT.
    - Presses during PROMPT are ignored and not counted.
  - WAIT:
    - Press with key_code==lib_note goes to ADVANCE.
    - Press with a different key_code increments mistakes, saturating at all-ones, and stays in WAIT.
  - ADVANCE, one cycle:
    - If lib_index==SONG_LEN-1: go to DONE.
    - Otherwise lib_index+1, then PROMPT.
  - DONE: done=1, busy=0, timer frozen, level latched. start goes to PROMPT with a fresh run.
- start is honoured in every non-IDLE state as a restart, with the same effect as from IDLE. start has priority over any simultaneous press or expiry.
- busy=1 in PROMPT, WAIT and ADVANCE.
- Timer:
  - Enabled from the first ADVANCE (first note cleared or rest passed) until DONE.
  - The prescaler counts 0..TICK_DIV-1, then increments elapsed_sec, saturating.
  - The prescaler clears on start.
- Grade at the ADVANCE→DONE transition:
  - Base grade: 3 if elapsed_sec<T_A; else 2 if <T_B; else 1 if <T_C; else 0.
  - level = base minus (mistakes / MISS_PEN), floored at 0.
- Index wrap is impossible because SONG_LEN ≤ 2^IDX_W−1. A SONG_LEN violation is an elaboration error.

Decomposition:
- Shared package learn_pkg holds the state enum (IDLE, PROMPT, WAIT, ADVANCE, DONE), the REST note code constant, and the grade function.
- One sub-module, sec_timer: prescaler plus saturating seconds counter, with enable/clear.

Test Plan:
- Reset mid-WAIT (rst low 1 cycle) → all outputs 0, state IDLE; a later start restarts at lib_index=0.
- SONG_LEN=3, durations 10, correct keys pressed 5 cycles after each prompt ends → three note_buzzed pulses, done=1, mistakes=0, level=3 (TICK_DIV=100 reduced).
- Two wrong presses then one correct; the key is held 50 cycles each time → mistakes=2, a single advance per press, held key not repeated.
- A press during PROMPT → ignored; mistakes unchanged; still in WAIT afterwards.
- Rest note (lib_note=0, duration 8) → play_note stays 0, note_buzzed pulses, auto-advance 8 cycles later with no key.
- Slow run: elapsed_sec=65, mistakes=5, MISS_PEN=4 → base 1 − 1 = level 0. Start pulse during DONE → done clears, lib_index=0.
